piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in, serial-out frame transmitter built on the team's D flip-flop style: clock clk0, serial line Q0.
- Registers one WIDTH-bit word and shifts it out LSB first with a start bit and a stop bit.
- Produces the single-bit stream that our flop-based capture stages sample; it is the driving end of that serial line.
- Sits between a parallel producer (ready/load handshake) and a one-wire serial link.

Parameters:
- WIDTH, 8, data word width in bits (>=2).

Ports:
- clk0  input  1  clock; all state updates on rising edge.
- Ra_n  input  1  asynchronous reset, active-low; forces idle state immediately.
- Rs  input  1  synchronous clear; aborts any frame on the next edge.
- D0  input  WIDTH  parallel data word; sampled only when accepted.
- load  input  1  producer request; word accepted when load && ready at a rising edge.
- ready  output  1  transmitter can accept a word this cycle.
- Q0  output  1  serial line, registered; idle level 1.
- busy  output  1  registered; high while a frame (start..stop) is on Q0.
- done  output  1  registered single-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset (Ra_n=0, asynchronous):
  - state=IDLE, Q0=1, busy=0, done=0, shift register=0, bit counter=0.
  - ready=1 once the state is IDLE.
- States: IDLE, START, SHIFT, STOP. ready = (state==IDLE) || (state==STOP), decoded combinationally from registered state.
- IDLE: Q0=1. On load&&ready: capture D0 into the shift register, go to START.
- START: Q0=0 for exactly one cycle, busy=1. Next state is SHIFT with counter=0.
- SHIFT:
  - Q0 = shift register bit 0; shift right each cycle; counter increments.
  - Lasts exactly WIDTH cycles. After the cycle with counter==WIDTH-1, go to STOP.
  - Counter width is clog2(WIDTH); no wrap inside a frame.
- STOP: Q0=1 for one cycle, done=1 for that cycle only, busy=1.
  - If load is high in STOP, capture D0 and go to START (back-to-back, exactly one stop bit).
  - Otherwise go to IDLE; busy drops to 0.
- Latency: the edge that accepts the word drives the start bit onward. Data bit k appears k+1 cycles after the start bit. Frame length is WIDTH+2 cycles.
- load while ready=0 is ignored. D0 changes mid-frame have no effect.
- Rs=1 at an edge:
  - Overrides load and every state; next state IDLE, Q0=1, busy=0, done=0.
  - An in-flight word is dropped.
- Ra_n asserted mid-frame: immediate return to reset values; no partial stop bit.
- Simultaneous Rs and load: Rs wins and the word is not accepted.

Optional Feature:
- Macro PISO_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between SHIFT and STOP.
  - Q0 = even parity (XOR of all WIDTH captured bits) for one cycle.
  - Frame length becomes WIDTH+3. done still pulses in the STOP cycle.
  - ready is unchanged: high in IDLE and STOP only, low in PARITY.
- Undefined: no PARITY state; frame is WIDTH+2 cycles, as above.

Test Plan:
- Reset: hold Ra_n=0 for 3 cycles with load=1 -> Q0=1, busy=0, done=0, ready=1. Release; D0=8'hA5 with load for 1 cycle -> Q0 over 10 cycles = 0,1,0,1,0,0,1,0,1,1; done high only in cycle 10; busy low afterward.
- Back-to-back: load 8'hA5, then hold load=1 with D0=8'h3C during STOP -> second start bit immediately follows the single stop bit; Q0 for the second frame = 0,0,0,1,1,1,1,0,0,1.
- Ignored load: pulse load with D0=8'hFF during SHIFT of an 8'h00 frame -> Q0 data bits all 0; no extra frame is sent.
- Sync abort: assert Rs for 1 cycle in SHIFT bit 3 -> next cycle Q0=1, busy=0, ready=1, no done pulse. Same-edge Rs=1 with load=1 in IDLE -> no frame.
- Async reset mid-frame: drop Ra_n between clock edges during SHIFT -> Q0=1 and busy=0 before the next edge.
- PISO_TX_PARITY_EN defined: 8'hA5 -> 11-cycle frame 0,1,0,1,0,0,1,0,1,0,1. 8'h07 -> parity bit 1.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Optional even-parity bit before the stop bit when PISO_TX_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk0,
    input  logic             Ra_n,
    input  logic             Rs,
    input  logic [WIDTH-1:0] D0,
    input  logic             load,
    output logic             ready,
    output logic             Q0,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
`ifdef PISO_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
`ifdef PISO_TX_PARITY_EN
    logic             par;
`endif

    assign ready = (state == IDLE) || (state == STOP);

    // Outputs are registered alongside the state, so Q0 always shows the bit of the current state.
    always_ff @(posedge clk0 or negedge Ra_n) begin
        if (!Ra_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            Q0    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (Rs) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            Q0    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (load) begin
                        state <= START;
                        sr    <= D0;
                        Q0    <= 1'b0;
                        busy  <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                        par   <= ^D0;
`endif
                    end else begin
                        state <= IDLE;
                        Q0    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    state <= SHIFT;
                    cnt   <= '0;
                    Q0    <= sr[0];
                    sr    <= sr >> 1;
                end
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef PISO_TX_PARITY_EN
                        state <= PARITY;
                        Q0    <= par;
`else
                        state <= STOP;
                        Q0    <= 1'b1;
                        done  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        Q0  <= sr[0];
                        sr  <= sr >> 1;
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    Q0    <= 1'b1;
                    done  <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    Q0    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
